// File: rtl/multmod_detect.sv
// rtl/multmod_detect.sv - serial MSB-first multiple-of-MOD detector on dual-rail channels
//
// Consumes one bit per four-phase handshake (codeword, then spacer) and answers
// each bit on a dual-rail output: parity1 = value so far is a multiple of MOD,
// parity0 = it is not. Both rails are low except in HOLD.

module multmod_detect #(
  parameter int MOD        = 3,
  parameter int W          = $clog2(MOD),
  parameter int FRAME_BITS = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0,
  input  logic         in1,
  output logic         parity0,
  output logic         parity1,
  output logic [W-1:0] remainder,
  output logic         err
);

  localparam int        WP        = W + 1;
  localparam logic [W:0] MOD_S    = WP'(MOD);
  localparam logic [15:0] FRAME_LIM = 16'(FRAME_BITS);
  localparam bit        FRAMED    = (FRAME_BITS > 0);

  typedef enum logic [1:0] {
    WAIT_NULL = 2'd0,
    IDLE      = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] bit_cnt;

  // Rails as seen by the decoder.
  logic d0;
  logic d1;

`ifdef MULTMOD_SYNC_EN
  logic [1:0] sync0;
  logic [1:0] sync1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 2'b00;
      sync1 <= 2'b00;
    end else begin
      sync0 <= {sync0[0], in0};
      sync1 <= {sync1[0], in1};
    end
  end

  assign d0 = sync0[1];
  assign d1 = sync1[1];
`else
  assign d0 = in0;
  assign d1 = in1;
`endif

  // Codeword decode.
  logic valid;
  logic illegal;
  logic spacer;
  logic bit_in;

  assign valid   = d0 ^ d1;
  assign illegal = d0 & d1;
  assign spacer  = ~d0 & ~d1;
  assign bit_in  = d1;

  // s = 2*remainder + bit never exceeds 2*MOD-1, so one conditional
  // subtract brings it back into range.
  logic [W:0]   s;
  logic [W-1:0] nxt;

  always_comb begin
    s   = {remainder, bit_in};
    nxt = (s >= MOD_S) ? W'(s - MOD_S) : W'(s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_NULL;
      parity0   <= 1'b0;
      parity1   <= 1'b0;
      remainder <= '0;
      bit_cnt   <= '0;
      err       <= 1'b0;
    end else if (illegal) begin
      // An illegal codeword freezes everything except the sticky flag.
      err <= 1'b1;
    end else begin
      case (state)
        // A codeword still present when reset lifts must not be counted,
        // so wait for a spacer before accepting data.
        WAIT_NULL: begin
          if (spacer) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (valid) begin
            remainder <= nxt;
            parity1   <= (nxt == '0);
            parity0   <= (nxt != '0);
            bit_cnt   <= bit_cnt + 16'd1;
            state     <= HOLD;
          end
        end

        // A different valid codeword without a spacer is ignored here.
        HOLD: begin
          if (spacer) begin
            parity0 <= 1'b0;
            parity1 <= 1'b0;
            state   <= IDLE;
            // The last bit of a frame has already been reported; the clear
            // takes effect on its return-to-zero.
            if (FRAMED && (bit_cnt == FRAME_LIM)) begin
              remainder <= '0;
              bit_cnt   <= '0;
            end
          end
        end

        default: begin
          state <= WAIT_NULL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multmod_detect.sv
// tb/tb_multmod_detect.sv - scoreboard testbench for multmod_detect

module tb_multmod_detect;

  localparam int MOD_A   = 3;
  localparam int MOD_B   = 5;
  localparam int FRAME_B = 3;

  logic clk;
  logic rst_n;
  logic in0;
  logic in1;

  logic       p0_a, p1_a, err_a;
  logic [1:0] rem_a;
  logic       p0_b, p1_b, err_b;
  logic [2:0] rem_b;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: A is unframed (rolling value mod 3),
  // B keeps the plain integer value of the current 3-bit frame.
  int acc_a  = 0;
  int fval_b = 0;
  int fcnt_b = 0;

  int exp_a[$];
  int exp_b[$];
  int rtz_a[$];
  int rtz_b[$];

  bit prev_a = 0;
  bit prev_b = 0;
  int e_a;
  int e_b;

  multmod_detect #(.MOD(MOD_A), .FRAME_BITS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1),
    .parity0(p0_a), .parity1(p1_a), .remainder(rem_a), .err(err_a)
  );

  multmod_detect #(.MOD(MOD_B), .FRAME_BITS(FRAME_B)) u_b (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1),
    .parity0(p0_b), .parity1(p1_b), .remainder(rem_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = 0;
    end else begin
      if ((p0_a | p1_a) && !prev_a) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_response", 1, 0);
        end else begin
          e_a = exp_a.pop_front();
          chk("a_remainder", int'(rem_a), e_a);
          chk("a_parity1", int'(p1_a), int'(e_a == 0));
          chk("a_parity0", int'(p0_a), int'(e_a != 0));
        end
      end else if (!(p0_a | p1_a) && prev_a) begin
        if (rtz_a.size() == 0) chk("a_unexpected_rtz", 1, 0);
        else chk("a_rtz_remainder", int'(rem_a), rtz_a.pop_front());
      end
      prev_a = p0_a | p1_a;
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_b = 0;
    end else begin
      if ((p0_b | p1_b) && !prev_b) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_response", 1, 0);
        end else begin
          e_b = exp_b.pop_front();
          chk("b_remainder", int'(rem_b), e_b);
          chk("b_parity1", int'(p1_b), int'(e_b == 0));
          chk("b_parity0", int'(p0_b), int'(e_b != 0));
        end
      end else if (!(p0_b | p1_b) && prev_b) begin
        if (rtz_b.size() == 0) chk("b_unexpected_rtz", 1, 0);
        else chk("b_rtz_remainder", int'(rem_b), rtz_b.pop_front());
      end
      prev_b = p0_b | p1_b;
    end
  end

  task automatic wait_rails(input bit want);
    bit ok;
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (((p0_a | p1_a) == want) && ((p0_b | p1_b) == want)) begin
        ok = 1;
        break;
      end
    end
    chk(want ? "rail_rise_timeout" : "rail_drop_timeout", int'(ok), 1);
  endtask

  task automatic model_bit(input bit b);
    acc_a = (acc_a * 2 + int'(b)) % MOD_A;
    exp_a.push_back(acc_a);
    fval_b = fval_b * 2 + int'(b);
    fcnt_b++;
    exp_b.push_back(fval_b % MOD_B);
  endtask

  task automatic model_reset();
    acc_a  = 0;
    fval_b = 0;
    fcnt_b = 0;
  endtask

  task automatic send_bit(input bit b, input bit wiggle);
    model_bit(b);
    @(posedge clk); #1;
    in0 = ~b;
    in1 = b;
    wait_rails(1'b1);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (wiggle) begin
      // Other valid codeword without a spacer: must be ignored.
      in0 = b;
      in1 = ~b;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    rtz_a.push_back(acc_a);
    if (fcnt_b == FRAME_B) begin
      fval_b = 0;
      fcnt_b = 0;
    end
    rtz_b.push_back(fval_b % MOD_B);
    @(posedge clk); #1;
    in0 = 1'b0;
    in1 = 1'b0;
    wait_rails(1'b0);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_outputs"}, int'({p0_a, p1_a, rem_a, err_a}), 0);
    chk({tag, "_b_outputs"}, int'({p0_b, p1_b, rem_b, err_b}), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in0   = 1'b0;
    in1   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Directed: 1,0,1 -> A: 1,2,2 ; B: 1,2,0 then frame clears.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);

    // Illegal codeword while idle: err sets, nothing else moves.
    @(posedge clk); #1;
    in0 = 1'b1;
    in1 = 1'b1;
    @(posedge clk); #1;
    in0 = 1'b0;
    in1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_err_set", int'(err_a), 1);
    chk("b_err_set", int'(err_b), 1);
    chk("a_rem_after_illegal", int'(rem_a), acc_a);
    chk("b_rem_after_illegal", int'(rem_b), fval_b % MOD_B);
    chk("rails_after_illegal", int'({p0_a, p1_a, p0_b, p1_b}), 0);

    // Randomized stream.
    for (int i = 0; i < 40; i++) begin
      send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    chk("a_err_sticky", int'(err_a), 1);
    chk("b_err_sticky", int'(err_b), 1);

    // Reset in HOLD with in1 still asserted.
    model_bit(1'b1);
    @(posedge clk); #1;
    in0 = 1'b0;
    in1 = 1'b1;
    wait_rails(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("hold_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_response_held_codeword", int'({p0_a, p1_a, p0_b, p1_b}), 0);
    @(posedge clk); #1;
    in1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending_responses", exp_a.size() + exp_b.size(), 0);
    chk("pending_rtz", rtz_a.size() + rtz_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multmod_detect.md
# multmod_detect

Clocked, parametrised successor to the dual-rail multiple-of-three detector. Consumes a serial, MSB-first bit stream on a dual-rail four-phase input channel and answers each bit on a dual-rail output channel. The answer says whether the bits received so far form a multiple of MOD: parity1 means multiple, parity0 means not a multiple. It sits between a dual-rail producer and a dual-rail consumer. It adds a configurable modulus, optional framing, a remainder readout and illegal-codeword detection.

## Interface
- MOD, 3: modulus; legal range 2..255.
- W, $clog2(MOD): remainder width; derived, never overridden.
- FRAME_BITS, 0: bits per frame; 0 means unframed (remainder never auto-clears); legal range 0..65535.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in0  input  1  data rail for bit value 0.
- in1  input  1  data rail for bit value 1. Both rails low is the spacer; both rails high is illegal.
- parity0  output  1  asserted: the accumulated value is not a multiple of MOD.
- parity1  output  1  asserted: the accumulated value is a multiple of MOD.
- remainder  output  W  current accumulated value mod MOD.
- err  output  1  sticky illegal-codeword flag.

## Operation
- Codeword decode: valid = in0 ^ in1; bit = in1; illegal = in0 & in1.
- Arithmetic: s = 2*remainder + bit, computed in W+1 bits. next = (s >= MOD) ? s - MOD : s. A single conditional subtract is sufficient because s ≤ 2*MOD-1.
- State WAIT_NULL: this is the reset state. Transitions to IDLE on the first cycle where the spacer is seen.
- State IDLE: on a valid codeword:
  - remainder <= next;
  - parity1 <= (next == 0), parity0 <= (next != 0);
  - bit counter increments;
  - go to HOLD.
- State HOLD: hold outputs; on the spacer, clear parity0/parity1 and go to IDLE.
  - A changed valid codeword without an intervening spacer is ignored.
- Framing (FRAME_BITS > 0):
  - When a HOLD→IDLE return-to-zero completes the FRAME_BITS-th bit, remainder and the bit counter clear to 0 on that same edge.
  - The response for the last bit of a frame is still reported from the pre-clear value.
- Illegal codeword in any state:
  - err <= 1;
  - no change to FSM state, remainder, counter or parity outputs;
  - err clears only on reset.
- Exactly one of parity0/parity1 is high in HOLD; both are low in every other state.
- Reset (rst_n low at an edge, including mid-handshake):
  - parity0 = 0, parity1 = 0, remainder = 0, err = 0, bit counter = 0;
  - state = WAIT_NULL.
  - A codeword still held on the inputs after reset is therefore not counted.

## Timing
- Reset values: parity0 0, parity1 0, remainder 0, err 0.
- Input-to-output latency is 1 clk: a valid codeword sampled at edge k is visible on the parity rail and remainder after edge k.
- Return-to-zero latency is 1 clk: a spacer sampled at edge k drops the parity rail after edge k.
- Minimum handshake is 2 clk per bit (valid cycle + spacer cycle).
- Inputs must be glitch-free at clk when MULTMOD_SYNC_EN is absent.
- Illegal codeword sets err 1 clk after it is sampled.
- Reset asserted and a codeword arriving on the same edge: reset wins.

## Configuration
- MULTMOD_SYNC_EN defined:
  - in0 and in1 each pass through a two-flop synchronizer before decode;
  - all input-referenced latencies grow by 2 clk (valid→parity 3 clk, spacer→RTZ 3 clk);
  - synchronizer flops reset to 0.
- MULTMOD_SYNC_EN undefined: in0 and in1 feed the decode directly; latencies are as stated under Timing.

## Test plan
- MOD=3, stream 1,1 with spacers between bits: first bit gives parity0=1, remainder=1; second bit gives parity1=1, remainder=0; both rails are 0 after each spacer.
- MOD=5, stream 1,0,1 (value 5): remainders 1, 2, 0. Responses are parity0, parity0, parity1.
- MOD=3, in0=in1=1 for 1 clk in IDLE, then a spacer: err=1 and stays 1; remainder unchanged; no parity rail asserted.
- MOD=3, FRAME_BITS=2, stream 1,0 then 1:
  - bit 2 reports parity0 with remainder=2;
  - after its spacer, remainder=0;
  - bit 3 reports remainder=1, parity0.
- Reset pulsed during HOLD with in1 held high: all outputs 0 next cycle; no response until a spacer then a new codeword; in1 then gives remainder=1.
- With MULTMOD_SYNC_EN: codeword applied at edge k appears on the parity rail after edge k+2; without the macro, after edge k.
